id_ex_ctrl_stage: RTL and testbench

//  Producer side of the ALUOp/func interface: decodes the IF/ID instruction into main control bits
//  (incl. 2-bit ALUOp) and registers them with operands into the ID/EX pipeline register that feeds
//  the ALU control and ALU. Handles stall, flush and illegal-opcode bubbles; 1-cycle latency.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/main_ctrl_dec.sv | 42 ++++
 rtl/id_ex_ctrl_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_ctrl_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the main-control bundle used by the ID stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  localparam logic [5:0] FUNC_ADD = 6'd32;
  localparam logic [5:0] FUNC_SUB = 6'd34;
  localparam logic [5:0] FUNC_AND = 6'd36;
  localparam logic [5:0] FUNC_SLL = 6'd0;
  localparam logic [5:0] FUNC_SRL = 6'd2;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BEQ   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/main_ctrl_dec.sv
// Main control decoder: opcode -> control bundle plus an illegal-opcode flag.
module main_ctrl_dec
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctrl    = '0;
    illegal = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = (rd != 5'd0);
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = (rt != 5'd0);
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALUOP_MEM;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_MEM;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_BEQ;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID stage control decode and ID/EX pipeline register with stall, flush and bubbles.
// Define ID_EX_HAZARD_DETECT_EN to enable load-use hazard detection (id_stall_o).
module id_ex_ctrl_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [31:0]   instr_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic [DW-1:0] pc4_i,
  output logic          id_stall_o,
  output logic          illegal_o,
  output logic          ex_valid_o,
  output logic [1:0]    ex_alu_op_o,
  output logic [5:0]    ex_func_o,
  output logic [4:0]    ex_shamt_o,
  output logic [DW-1:0] ex_a_o,
  output logic [DW-1:0] ex_b_o,
  output logic [DW-1:0] ex_imm_o,
  output logic [RW-1:0] ex_rs_o,
  output logic [RW-1:0] ex_rt_o,
  output logic [RW-1:0] ex_rd_o,
  output logic [DW-1:0] ex_pc4_o,
  output logic          ex_reg_dst_o,
  output logic          ex_alu_src_o,
  output logic          ex_mem_to_reg_o,
  output logic          ex_reg_write_o,
  output logic          ex_mem_read_o,
  output logic          ex_mem_write_o,
  output logic          ex_branch_o
);

  typedef struct packed {
    logic          valid;
    ctrl_t         ctrl;
    logic [5:0]    func;
    logic [4:0]    shamt;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [DW-1:0] pc4;
  } stage_t;

  ctrl_t  dec_ctrl;
  logic   dec_illegal;
  stage_t decoded;
  stage_t q;
  logic   illegal_q;

  main_ctrl_dec u_dec (
    .opcode  (instr_i[31:26]),
    .rt      (instr_i[20:16]),
    .rd      (instr_i[15:11]),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_comb begin
    decoded       = '0;
    decoded.valid = 1'b1;
    decoded.ctrl  = dec_ctrl;
    decoded.func  = instr_i[5:0];
    decoded.shamt = instr_i[10:6];
    decoded.a     = rs_data_i;
    decoded.b     = rt_data_i;
    decoded.imm   = {{(DW-16){instr_i[15]}}, instr_i[15:0]};
    decoded.rs    = RW'(instr_i[25:21]);
    decoded.rt    = RW'(instr_i[20:16]);
    decoded.rd    = RW'(instr_i[15:11]);
    decoded.pc4   = pc4_i;
  end

`ifdef ID_EX_HAZARD_DETECT_EN
  // Only R-type, sw and beq actually read rt as a source operand.
  logic uses_rt;
  assign uses_rt = (instr_i[31:26] == OP_RTYPE) || (instr_i[31:26] == OP_SW) ||
                   (instr_i[31:26] == OP_BEQ);
  assign id_stall_o = q.valid && q.ctrl.mem_read && (q.rt != '0) &&
                      ((q.rt == RW'(instr_i[25:21])) ||
                       (uses_rt && (q.rt == RW'(instr_i[20:16]))));
`else
  assign id_stall_o = 1'b0;
`endif

  // An all-zero instruction (sll $0,$0,0) has no effect, so it enters EX as a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q         <= '0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking default first; later branches override it within the same edge.
      illegal_q <= 1'b0;
      if (flush_i) begin
        q <= '0;
      end else if (stall_i) begin
        q <= q;
      end else if (id_stall_o || dec_illegal || (instr_i == '0)) begin
        q         <= '0;
        illegal_q <= dec_illegal && !id_stall_o;
      end else begin
        q <= decoded;
      end
    end
  end

  assign illegal_o       = illegal_q;
  assign ex_valid_o      = q.valid;
  assign ex_alu_op_o     = q.ctrl.alu_op;
  assign ex_func_o       = q.func;
  assign ex_shamt_o      = q.shamt;
  assign ex_a_o          = q.a;
  assign ex_b_o          = q.b;
  assign ex_imm_o        = q.imm;
  assign ex_rs_o         = q.rs;
  assign ex_rt_o         = q.rt;
  assign ex_rd_o         = q.rd;
  assign ex_pc4_o        = q.pc4;
  assign ex_reg_dst_o    = q.ctrl.reg_dst;
  assign ex_alu_src_o    = q.ctrl.alu_src;
  assign ex_mem_to_reg_o = q.ctrl.mem_to_reg;
  assign ex_reg_write_o  = q.ctrl.reg_write;
  assign ex_mem_read_o   = q.ctrl.mem_read;
  assign ex_mem_write_o  = q.ctrl.mem_write;
  assign ex_branch_o     = q.ctrl.branch;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Self-checking bench for id_ex_ctrl_stage: directed table, corner sequences, random vs model.
module tb_id_ex_ctrl_stage;

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall_i, flush_i;
  logic [31:0] instr_i, rs_data_i, rt_data_i, pc4_i;
  logic        id_stall_o, illegal_o, ex_valid_o;
  logic [1:0]  ex_alu_op_o;
  logic [5:0]  ex_func_o;
  logic [4:0]  ex_shamt_o, ex_rs_o, ex_rt_o, ex_rd_o;
  logic [31:0] ex_a_o, ex_b_o, ex_imm_o, ex_pc4_o;
  logic        ex_reg_dst_o, ex_alu_src_o, ex_mem_to_reg_o, ex_reg_write_o;
  logic        ex_mem_read_o, ex_mem_write_o, ex_branch_o;

  always #5 clk = ~clk;

  id_ex_ctrl_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .instr_i(instr_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .pc4_i(pc4_i),
    .id_stall_o(id_stall_o), .illegal_o(illegal_o), .ex_valid_o(ex_valid_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_func_o(ex_func_o), .ex_shamt_o(ex_shamt_o),
    .ex_a_o(ex_a_o), .ex_b_o(ex_b_o), .ex_imm_o(ex_imm_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .ex_pc4_o(ex_pc4_o),
    .ex_reg_dst_o(ex_reg_dst_o), .ex_alu_src_o(ex_alu_src_o),
    .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_branch_o(ex_branch_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the EX stage should hold, derived from the instruction-set rules.
  typedef struct packed {
    bit        valid;
    bit [1:0]  alu_op;
    bit        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    bit        illegal;
    bit [5:0]  func;
    bit [4:0]  shamt, rs, rt, rd;
    bit [31:0] a, b, imm, pc4;
  } mstate_t;

  mstate_t m;
  logic    last_stall;

  function automatic mstate_t decode(input logic [31:0] ins, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] pc4);
    mstate_t d;
    int op, rt, rd;
    d  = '0;
    op = int'(ins[31:26]);
    rt = int'(ins[20:16]);
    rd = int'(ins[15:11]);
    if (ins == 32'd0) return d;
    case (op)
      0:  begin d.alu_op = 2; d.reg_dst = 1; d.reg_write = (rd != 0); end
      35: begin d.alu_op = 0; d.alu_src = 1; d.mem_to_reg = 1; d.mem_read = 1;
                d.reg_write = (rt != 0); end
      43: begin d.alu_op = 0; d.alu_src = 1; d.mem_write = 1; end
      4:  begin d.alu_op = 1; d.branch = 1; end
      default: begin d.illegal = 1; return d; end
    endcase
    d.valid = 1;
    d.func  = ins[5:0];
    d.shamt = ins[10:6];
    d.rs    = ins[25:21];
    d.rt    = ins[20:16];
    d.rd    = ins[15:11];
    d.a     = a;
    d.b     = b;
    d.imm   = 32'($signed(ins[15:0]));
    d.pc4   = pc4;
    return d;
  endfunction

  function automatic bit model_hazard(input logic [31:0] ins);
    int op;
    bit reads_rt;
    op       = int'(ins[31:26]);
    reads_rt = (op == 0) || (op == 43) || (op == 4);
    return HZ && m.valid && m.mem_read && (m.rt != 0) &&
           ((m.rt == ins[25:21]) || (reads_rt && (m.rt == ins[20:16])));
  endfunction

  task automatic check_all();
    check("ctrl", {ex_valid_o, ex_alu_op_o, ex_reg_dst_o, ex_alu_src_o, ex_mem_to_reg_o,
                   ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o, illegal_o},
          {m.valid, m.alu_op, m.reg_dst, m.alu_src, m.mem_to_reg, m.reg_write,
           m.mem_read, m.mem_write, m.branch, m.illegal});
    check("fields", {ex_func_o, ex_shamt_o, ex_rs_o, ex_rt_o, ex_rd_o},
          {m.func, m.shamt, m.rs, m.rt, m.rd});
    check("ex_a", ex_a_o, m.a);
    check("ex_b", ex_b_o, m.b);
    check("ex_imm", ex_imm_o, m.imm);
    check("ex_pc4", ex_pc4_o, m.pc4);
  endtask

  // One cycle: drive inputs, check the comb hazard, clock, advance the model, check all outputs.
  task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc4, input logic st, input logic fl, input logic rn);
    bit hz;
    instr_i = ins; rs_data_i = a; rt_data_i = b; pc4_i = pc4;
    stall_i = st; flush_i = fl; rst_n = rn;
    #1;
    hz = model_hazard(ins);
    last_stall = id_stall_o;
    check("id_stall", id_stall_o, hz);
    @(posedge clk);
    if (!rn || fl || (!st && hz)) m = '0;
    else if (st) m.illegal = 0;
    else m = decode(ins, a, b, pc4);
    #1;
    check_all();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a, b;
    logic        fl;
    logic [10:0] exp_ctrl;  // valid, alu_op, reg_dst..branch, illegal
    logic [5:0]  exp_func;
    logic [4:0]  exp_rd;
    logic [31:0] exp_imm;
  } vec_t;

  vec_t vecs[10];

  localparam logic [31:0] ADD_3_1_2 = 32'h0022_1820;
  localparam logic [31:0] ADD_4_2_5 = 32'h0045_2020;
  localparam logic [31:0] LW_2_8_1  = 32'h8C22_0008;
  localparam logic [31:0] BEQ_1_2_M4 = 32'h1022_FFFC;
  localparam logic [31:0] SW_2_4_1  = 32'hAC22_0004;
  localparam logic [31:0] ILL_63    = 32'hFC00_0000;

  initial begin
    vecs[0] = '{ADD_3_1_2,    5,  7, 0, 11'b1_10_1001000_0, 6'd32, 5'd3,  32'h0000_1820};
    vecs[1] = '{32'h0085_3022, 9,  3, 0, 11'b1_10_1001000_0, 6'd34, 5'd6,  32'h0000_3022};
    vecs[2] = '{LW_2_8_1,     1,  2, 0, 11'b1_00_0111100_0, 6'd8,  5'd0,  32'h0000_0008};
    vecs[3] = '{32'h1064_FFFC, 4,  4, 0, 11'b1_01_0000001_0, 6'd60, 5'd31, 32'hFFFF_FFFC};
    vecs[4] = '{32'hACC5_0004, 6,  8, 0, 11'b1_00_0100010_0, 6'd4,  5'd0,  32'h0000_0004};
    vecs[5] = '{32'h0000_0000, 3,  3, 0, 11'b0_00_0000000_0, 6'd0,  5'd0,  32'h0};
    vecs[6] = '{ILL_63,       2,  2, 0, 11'b0_00_0000000_1, 6'd0,  5'd0,  32'h0};
    vecs[7] = '{32'h0022_0024, 7,  1, 0, 11'b1_10_1000000_0, 6'd36, 5'd0,  32'h0000_0024};
    vecs[8] = '{32'h8C20_0000, 8,  9, 0, 11'b1_00_0110100_0, 6'd0,  5'd0,  32'h0};
    vecs[9] = '{ADD_3_1_2,    5,  7, 1, 11'b0_00_0000000_0, 6'd0,  5'd0,  32'h0};

    rst_n = 0; stall_i = 0; flush_i = 0;
    instr_i = ADD_3_1_2; rs_data_i = 0; rt_data_i = 0; pc4_i = 0;
    m = '0;
    @(posedge clk);

    // Reset held two cycles with a live add on the input.
    step(ADD_3_1_2, 5, 7, 32'h100, 0, 0, 0);
    step(ADD_3_1_2, 5, 7, 32'h100, 0, 0, 0);
    check("rst_valid", ex_valid_o, 1'b0);
    check("rst_illegal", illegal_o, 1'b0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].instr, vecs[i].a, vecs[i].b, 32'h400 + 32'(4 * i), 0, vecs[i].fl, 1);
      check($sformatf("vec%0d_ctrl", i),
            {ex_valid_o, ex_alu_op_o, ex_reg_dst_o, ex_alu_src_o, ex_mem_to_reg_o,
             ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o, illegal_o},
            vecs[i].exp_ctrl);
      check($sformatf("vec%0d_func", i), ex_func_o, vecs[i].exp_func);
      check($sformatf("vec%0d_rd", i), ex_rd_o, vecs[i].exp_rd);
      check($sformatf("vec%0d_imm", i), ex_imm_o, vecs[i].exp_imm);
      check($sformatf("vec%0d_a", i), ex_a_o, vecs[i].exp_ctrl[10] ? vecs[i].a : 32'h0);
    end

    // Load-use: lw $2 then add $4,$2,$5.
    step(LW_2_8_1, 1, 2, 32'h500, 0, 0, 1);
    step(ADD_4_2_5, 11, 12, 32'h504, 0, 0, 1);
    check("lu_stall", last_stall, HZ);
    check("lu_bubble_valid", ex_valid_o, !HZ);
    step(ADD_4_2_5, 11, 12, 32'h504, 0, 0, 1);
    check("lu_stall_clear", last_stall, 1'b0);
    check("lu_add_valid", ex_valid_o, 1'b1);
    check("lu_add_rd", ex_rd_o, 5'd4);

    // beq then beq with flush.
    step(BEQ_1_2_M4, 3, 3, 32'h600, 0, 0, 1);
    check("beq_aluop", ex_alu_op_o, 2'b01);
    check("beq_imm", ex_imm_o, 32'hFFFF_FFFC);
    step(BEQ_1_2_M4, 3, 3, 32'h604, 0, 1, 1);
    check("beq_flush", {ex_valid_o, ex_branch_o, ex_alu_op_o}, 4'b0);

    // Illegal opcode pulse, then stall+flush together.
    step(ILL_63, 1, 1, 32'h700, 0, 0, 1);
    check("ill_pulse", {illegal_o, ex_valid_o}, 2'b10);
    step(ADD_3_1_2, 5, 7, 32'h704, 1, 1, 1);
    check("ill_clear_flush", {illegal_o, ex_valid_o}, 2'b00);

    // sw held off by stall_i for three cycles behind an add.
    step(ADD_3_1_2, 5, 7, 32'h800, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(SW_2_4_1, 9, 11, 32'h804, 1, 0, 1);
      check($sformatf("stall%0d_hold", i), {ex_valid_o, ex_func_o, ex_a_o}, {1'b1, 6'd32, 32'd5});
    end
    step(SW_2_4_1, 9, 11, 32'h804, 0, 0, 1);
    check("sw_ctrl", {ex_mem_write_o, ex_alu_src_o, ex_alu_op_o, ex_reg_write_o}, 5'b11000);
    check("sw_a", ex_a_o, 32'd9);

    // Reset during a stall clears everything.
    step(ADD_3_1_2, 5, 7, 32'h900, 1, 0, 0);
    check("rst_stall", {ex_valid_o, ex_a_o}, 33'd0);

    // Random traffic; small register indices make hazards common.
    begin
      logic [31:0] ins;
      ins = 32'h0;
      for (int i = 0; i < 400; i++) begin
        if (!last_stall) begin
          int sel;
          logic [5:0] op;
          sel = int'($urandom_range(0, 9));
          case (sel)
            0, 1, 2: op = 6'd0;
            3, 4:    op = 6'd35;
            5:       op = 6'd43;
            6:       op = 6'd4;
            default: op = 6'($urandom);
          endcase
          ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 11'($urandom)};
        end
        step(ins, $urandom, $urandom, $urandom,
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 49) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
